sstl_tx_sequencer: RTL and testbench
====================================

SSTL_TX_SEQUENCER -- requirements
Module: sstl_tx_sequencer

Interface
- REQ-001 SHALL provide parameter WIDTH, default 8: data word width in bits, legal range 2..32.
- REQ-002 SHALL provide parameter LEAD, default 2: cycles the pad is driven low before the first data bit, legal range 0..15.
- REQ-003 SHALL provide parameter TRAIL, default 1: cycles the pad is driven low after the last data bit, legal range 0..15.
- REQ-004 SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
- REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous to CLK and active-high.
- REQ-006 SHALL have port DIN, input, WIDTH bits: parallel word to transmit, MSB first.
- REQ-007 SHALL have port DVALID, input, 1 bit: DIN holds a valid word.
- REQ-008 SHALL have port DREADY, output, 1 bit: the block accepts DIN on this cycle.
- REQ-009 SHALL have port O, output, 1 bit: serial data; drives the I input of the downstream tri-state output buffer.
- REQ-010 SHALL have port T, output, 1 bit: tri-state control, 1 = pad released (high-Z); drives the T input of the downstream buffer.
- REQ-011 SHALL have port BUSY, output, 1 bit: high whenever the state is not IDLE.

Function
- REQ-012 SHALL implement four states: IDLE, LEAD, DATA and TRAIL.
- REQ-013 A handshake SHALL occur on a rising edge where DVALID=1 and DREADY=1; DIN is captured into a WIDTH-bit shift register on that edge.
- REQ-014 DREADY SHALL be combinational from state: 1 in IDLE, 1 in DATA on the last bit (bit counter = WIDTH-1), and 0 otherwise, including while RST=1.
- REQ-015 O and T SHALL be registered outputs with no combinational path from DIN or DVALID.
- REQ-016 IDLE SHALL present T=1 and O=0.
- REQ-017 On a handshake in IDLE, the next state SHALL be LEAD, or DATA directly if LEAD=0.
- REQ-018 LEAD SHALL last exactly LEAD cycles with T=0 and O=0, counted by a 4-bit down counter.
- REQ-019 DATA SHALL last WIDTH cycles per word with T=0, where O equals the word bit WIDTH-1-n on data cycle n (n=0..WIDTH-1).
- REQ-020 On the last data bit with a handshake, the new word SHALL be loaded and its MSB SHALL appear on O the next cycle; there is no LEAD, no TRAIL and no gap between back-to-back words.
- REQ-021 On the last data bit without a handshake, the next state SHALL be TRAIL, or IDLE directly if TRAIL=0.
- REQ-022 TRAIL SHALL last exactly TRAIL cycles with T=0 and O=0, then go to IDLE with T=1.
- REQ-023 DVALID asserted during LEAD, TRAIL or non-final DATA cycles SHALL be ignored, with no capture and no state change.
- REQ-024 DIN SHALL be ignored on any cycle without a handshake.
- REQ-025 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL wrap to 0 on each word reload.
- REQ-026 T SHALL never be 1 while the state is LEAD, DATA or TRAIL, so the pad is never released mid-frame.

Reset
- REQ-027 RST=1 at a rising edge SHALL force state IDLE, T=1, O=0, BUSY=0, and clear the counters and the shift register, regardless of state.
- REQ-028 Reset mid-frame SHALL release the pad (T=1) on the first edge at which RST is sampled high, without completing TRAIL.
- REQ-029 A handshake SHALL NOT occur while RST=1.
- REQ-030 DREADY SHALL read 1 on the first cycle after RST deasserts.

Verification
- REQ-031 Single word, WIDTH=8, LEAD=2, TRAIL=1, DIN=0xA5 accepted at edge k -> T=0 from k+1 to k+11; O=0,0 then 1,0,1,0,0,1,0,1 then 0; T=1 from k+12; BUSY matches.
- REQ-032 Back-to-back: 0xFF then 0x00, with DVALID held high -> 16 contiguous data bits (eight 1s, eight 0s), a single LEAD and a single TRAIL, and DREADY=1 exactly at the two accept cycles.
- REQ-033 LEAD=0, TRAIL=0, DIN=0x81 -> the MSB appears on O on the cycle after the handshake, and T=1 on the cycle after the last bit.
- REQ-034 DVALID pulsed during LEAD and TRAIL -> no capture, O sequence unchanged, DREADY=0 on those cycles.
- REQ-035 RST asserted on data bit 3 -> next cycle T=1, O=0, BUSY=0; after release DREADY=1 and a new word 0x3C transmits correctly.
- REQ-036 Randomized word stream with random DVALID gaps -> the serialized O bits, sampled while in DATA, equal the accepted words in order, and T=1 only while in IDLE.

Source files
------------

// File: rtl/sstl_tx_sequencer.sv
// Serialises parallel words MSB-first onto a tri-state pad, framing each burst
// with LEAD low cycles before and TRAIL low cycles after; the pad is released in IDLE.
module sstl_tx_sequencer #(
    parameter int WIDTH = 8,
    parameter int LEAD  = 2,
    parameter int TRAIL = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DVALID,
    output logic             DREADY,
    output logic             O,
    output logic             T,
    output logic             BUSY
);

    localparam int            CW         = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
    localparam logic [3:0]    LEAD_LOAD  = 4'((LEAD  > 0) ? LEAD  - 1 : 0);
    localparam logic [3:0]    TRAIL_LOAD = 4'((TRAIL > 0) ? TRAIL - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_DATA, S_TRAIL} state_t;

    state_t           state, state_n;
    logic [3:0]       phase_cnt, phase_cnt_n;
    logic [CW-1:0]    bit_cnt, bit_cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             hs;

    // Gating with RST keeps a handshake from ever landing on a reset edge.
    assign DREADY = !RST && ((state == S_IDLE) || ((state == S_DATA) && (bit_cnt == LAST_BIT)));
    assign BUSY   = (state != S_IDLE);
    assign hs     = DVALID && DREADY;

    always_comb begin
        // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        state_n     = state;
        phase_cnt_n = phase_cnt;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        case (state)
            S_IDLE: begin
                if (hs) begin
                    shreg_n   = DIN;
                    bit_cnt_n = '0;
                    if (LEAD > 0) begin
                        state_n     = S_LEAD;
                        phase_cnt_n = LEAD_LOAD;
                    end else begin
                        state_n = S_DATA;
                    end
                end
            end
            S_LEAD: begin
                if (phase_cnt == 4'd0) state_n = S_DATA;
                else                   phase_cnt_n = phase_cnt - 4'd1;
            end
            S_DATA: begin
                if (bit_cnt == LAST_BIT) begin
                    if (hs) begin
                        // Back-to-back word: reload with no gap, lead or trail.
                        shreg_n   = DIN;
                        bit_cnt_n = '0;
                    end else if (TRAIL > 0) begin
                        state_n     = S_TRAIL;
                        phase_cnt_n = TRAIL_LOAD;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + CW'(1);
                    shreg_n   = {shreg[WIDTH-2:0], 1'b0};
                end
            end
            S_TRAIL: begin
                if (phase_cnt == 4'd0) state_n = S_IDLE;
                else                   phase_cnt_n = phase_cnt - 4'd1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // O and T are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (RST) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            T         <= 1'b1;
            O         <= 1'b0;
        end else begin
            state     <= state_n;
            phase_cnt <= phase_cnt_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            T         <= (state_n == S_IDLE);
            O         <= (state_n == S_DATA) && shreg_n[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_sstl_tx_sequencer.sv
// Scoreboard bench: two instances (LEAD=2/TRAIL=1 and LEAD=0/TRAIL=0) share stimulus;
// a frame-timeline model predicts each cycle's T/O/BUSY/DREADY and a negedge monitor compares.
module tb_sstl_tx_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] DIN = 8'h00;
    logic       DVALID = 1'b0;
    logic       rdy0, o0, t0, busy0;
    logic       rdy1, o1, t1, busy1;

    always #5 CLK = ~CLK;

    sstl_tx_sequencer #(.WIDTH(8), .LEAD(2), .TRAIL(1)) dut0 (
        .CLK(CLK), .RST(RST), .DIN(DIN), .DVALID(DVALID),
        .DREADY(rdy0), .O(o0), .T(t0), .BUSY(busy0)
    );

    sstl_tx_sequencer #(.WIDTH(8), .LEAD(0), .TRAIL(0)) dut1 (
        .CLK(CLK), .RST(RST), .DIN(DIN), .DVALID(DVALID),
        .DREADY(rdy1), .O(o1), .T(t1), .BUSY(busy1)
    );

    // One slot per future busy cycle: the bit on O, whether it is a word's last bit, whether it is trail.
    typedef struct packed { logic o; logic last; logic trl; } slot_t;
    typedef struct packed { logic t; logic o; logic busy; logic rdy; } exp_t;

    slot_t tl   [2][$];
    exp_t  expq [2][$];
    bit    known = 1'b0;
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc   = 0;
    int    n_acc [2] = '{0, 0};

    function automatic int lead_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic int trail_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int inst, input logic got, input logic want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s inst%0d cycle %0d: got %b expected %b", name, inst, cyc, got, want);
        end
    endtask

    task automatic model_expect(input int i, input bit r, output exp_t e);
        if (tl[i].size() == 0) begin
            e = '{t: 1'b1, o: 1'b0, busy: 1'b0, rdy: !r};
        end else begin
            e = '{t: 1'b0, o: tl[i][0].o, busy: 1'b1, rdy: !r && tl[i][0].last};
        end
    endtask

    task automatic model_edge(input int i, input bit hs, input bit r, input logic [7:0] w);
        bit was_idle;
        if (r) begin
            tl[i].delete();
            return;
        end
        was_idle = (tl[i].size() == 0);
        if (!was_idle) void'(tl[i].pop_front());
        if (hs) begin
            n_acc[i]++;
            if (was_idle) begin
                for (int k = 0; k < lead_of(i); k++) tl[i].push_back('{o: 1'b0, last: 1'b0, trl: 1'b0});
            end else begin
                while (tl[i].size() > 0 && tl[i][tl[i].size()-1].trl) void'(tl[i].pop_back());
            end
            for (int k = 7; k >= 0; k--) tl[i].push_back('{o: w[k], last: (k == 0), trl: 1'b0});
            for (int k = 0; k < trail_of(i); k++) tl[i].push_back('{o: 1'b0, last: 1'b0, trl: 1'b1});
        end
    endtask

    // Drive one cycle's inputs, predict that cycle's outputs, then advance the model at the edge.
    task automatic cycle(input bit r, input bit dv, input logic [7:0] d);
        bit   hs [2];
        exp_t e;
        RST = r; DVALID = dv; DIN = d;
        for (int i = 0; i < 2; i++) begin
            hs[i] = 1'b0;
            if (known) begin
                model_expect(i, r, e);
                expq[i].push_back(e);
                hs[i] = dv && e.rdy;
            end
        end
        @(posedge CLK);
        for (int i = 0; i < 2; i++) model_edge(i, hs[i], r, d);
        if (r) known = 1'b1;
        cyc++;
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 8'($urandom));
    endtask

    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (expq[i].size() > 0) begin
                exp_t e;
                e = expq[i].pop_front();
                check("T",      i, (i == 0) ? t0    : t1,    e.t);
                check("O",      i, (i == 0) ? o0    : o1,    e.o);
                check("BUSY",   i, (i == 0) ? busy0 : busy1, e.busy);
                check("DREADY", i, (i == 0) ? rdy0  : rdy1,  e.rdy);
            end
        end
    end

    initial begin
        @(posedge CLK);
        #1;
        known = 1'b1;
        cycle(1'b1, 1'b1, 8'hFF);
        idle_cycles(2);

        // Single word 0xA5 with junk on DIN afterwards.
        cycle(1'b0, 1'b1, 8'hA5);
        idle_cycles(14);

        // Back-to-back 0xFF then 0x00 with DVALID held until the second accept of the framed instance.
        cycle(1'b0, 1'b1, 8'hFF);
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 8'h00);
        idle_cycles(14);

        // 0x81, then DVALID pulses inside LEAD and TRAIL (and mid-word on the unframed instance).
        cycle(1'b0, 1'b1, 8'h81);
        cycle(1'b0, 1'b1, 8'h5A);
        for (int k = 0; k < 9; k++) cycle(1'b0, 1'b0, 8'($urandom));
        cycle(1'b0, 1'b1, 8'hC3);
        idle_cycles(14);

        // Reset on data bit 3 of the framed instance, then 0x3C.
        cycle(1'b0, 1'b1, 8'hE7);
        idle_cycles(5);
        cycle(1'b1, 1'b0, 8'h00);
        idle_cycles(1);
        cycle(1'b0, 1'b1, 8'h3C);
        idle_cycles(14);

        // Random stream with random DVALID gaps and the occasional reset.
        for (int k = 0; k < 600; k++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 55), 8'($urandom));
        end
        idle_cycles(14);

        @(negedge CLK);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("queue_drained", i, (expq[i].size() == 0), 1'b1);
            check("some_accepts",  i, (n_acc[i] > 10),       1'b1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
